// File: rtl/md5_pkg.sv
// Shared MD5 constants, message-word schedule, byteswap helper and FSM state encoding.
package md5_pkg;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_ROUND = 2'd1,
    E_FINAL = 2'd2,
    E_OUT   = 2'd3
  } md5_state_e;

  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hefcdab89;
  localparam logic [31:0] H2 = 32'h98badcfe;
  localparam logic [31:0] H3 = 32'h10325476;

  localparam logic [0:63][31:0] K = {
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [0:63][4:0] S = {
    {4{5'd7, 5'd12, 5'd17, 5'd22}},
    {4{5'd5, 5'd9,  5'd14, 5'd20}},
    {4{5'd4, 5'd11, 5'd16, 5'd23}},
    {4{5'd6, 5'd10, 5'd15, 5'd21}}
  };

  // 4-bit arithmetic wraps, which gives the mod-16 of the schedule for free
  function automatic logic [3:0] msg_idx(input logic [5:0] step);
    logic [3:0] i;
    i = step[3:0];
    case (step[5:4])
      2'd0:    return i;
      2'd1:    return i * 4'd5 + 4'd1;
      2'd2:    return i * 4'd3 + 4'd5;
      default: return i * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_param_core_if.sv
// Message-in / digest-out handshake bundle; MD5_MATCH_EN adds target and out_match.
interface md5_param_core_if #(parameter int MSG_BYTES = 8);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*MSG_BYTES-1:0] in_data;
  logic [5:0]             in_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [127:0]           out_digest;
`ifdef MD5_MATCH_EN
  logic [127:0]           target;
  logic                   out_match;

  modport master (output in_valid, in_data, in_len, out_ready, target,
                  input  in_ready, out_valid, out_digest, out_match);
  modport slave  (input  in_valid, in_data, in_len, out_ready, target,
                  output in_ready, out_valid, out_digest, out_match);
`else
  modport master (output in_valid, in_data, in_len, out_ready,
                  input  in_ready, out_valid, out_digest);
  modport slave  (input  in_valid, in_data, in_len, out_ready,
                  output in_ready, out_valid, out_digest);
`endif
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step; round function, K and rotate chosen by absolute step.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [5:0]  i_step,
  input  logic [31:0] i_m,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);
  logic [31:0] w_f;
  logic [31:0] w_sum;
  logic [31:0] w_rot;
  logic [4:0]  w_s;

  always_comb begin
    case (i_step[5:4])
      2'd0:    w_f = (i_b & i_c) | (~i_b & i_d);
      2'd1:    w_f = (i_d & i_b) | (~i_d & i_c);
      2'd2:    w_f = i_b ^ i_c ^ i_d;
      default: w_f = i_c ^ (i_b | ~i_d);
    endcase
  end

  assign w_s   = S[i_step];
  assign w_sum = i_a + w_f + K[i_step] + i_m;
  // shift amounts are never 0, so 0 - s == 32 - s in 5 bits
  assign w_rot = (w_sum << w_s) | (w_sum >> (5'd0 - w_s));

  assign o_a = i_d;
  assign o_b = i_b + w_rot;
  assign o_c = i_b;
  assign o_d = i_c;
endmodule

// File: rtl/md5_param_core.sv
// Single-block MD5 engine, UNROLL steps per clock. Optional MD5_MATCH_EN: digest==target flag.
module md5_param_core
  import md5_pkg::*;
#(
  parameter int MSG_BYTES = 8,
  parameter int UNROLL    = 1
) (
  input logic           clk,
  input logic           reset_n,
  md5_param_core_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = E_IDLE;
  localparam logic [1:0] ST_ROUND = E_ROUND;
  localparam logic [1:0] ST_FINAL = E_FINAL;
  localparam logic [1:0] ST_OUT   = E_OUT;
  localparam logic [5:0] LAST_IDX = 6'(64 - UNROLL);

  logic [1:0]        r_state;
  logic [5:0]        r_idx;
  logic [15:0][31:0] r_blk;
  logic [31:0]       r_a, r_b, r_c, r_d;
  logic [127:0]      r_digest;
`ifdef MD5_MATCH_EN
  logic              r_match;
`endif

  logic [63:0][7:0]  w_msg;
  logic [63:0][7:0]  w_pad;
  logic [15:0][31:0] w_words;
  logic [5:0]        w_len;
  logic [63:0]       w_bitlen;
  logic [127:0]      w_dig;
  logic [UNROLL:0][31:0] w_a, w_b, w_c, w_d;

  // byte 0 sits in the MSBs of in_data; bytes past MSG_BYTES are zero
  for (genvar k = 0; k < 64; k++) begin : g_msg
    if (k < MSG_BYTES) begin : g_byte
      assign w_msg[k] = bus.in_data[8*(MSG_BYTES-1-k) +: 8];
    end else begin : g_zero
      assign w_msg[k] = 8'h00;
    end
  end

  assign w_len    = (bus.in_len > 6'(MSG_BYTES)) ? 6'(MSG_BYTES) : bus.in_len;
  assign w_bitlen = {55'd0, w_len, 3'd0};

  always_comb begin
    w_pad = '0;
    for (int k = 0; k < 56; k++) begin
      if (k < int'(w_len))       w_pad[k] = w_msg[k];
      else if (k == int'(w_len)) w_pad[k] = 8'h80;
    end
    for (int k = 0; k < 8; k++) w_pad[56+k] = w_bitlen[8*k +: 8];
  end

  for (genvar j = 0; j < 16; j++) begin : g_word
    assign w_words[j] = {w_pad[4*j+3], w_pad[4*j+2], w_pad[4*j+1], w_pad[4*j]};
  end

  assign w_a[0] = r_a;
  assign w_b[0] = r_b;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    logic [5:0] w_sn;
    assign w_sn = r_idx + 6'(u);
    md5_step u_step (
      .i_a   (w_a[u]),
      .i_b   (w_b[u]),
      .i_c   (w_c[u]),
      .i_d   (w_d[u]),
      .i_step(w_sn),
      .i_m   (r_blk[msg_idx(w_sn)]),
      .o_a   (w_a[u+1]),
      .o_b   (w_b[u+1]),
      .o_c   (w_c[u+1]),
      .o_d   (w_d[u+1])
    );
  end

  assign w_dig = {bswap32(r_a + H0), bswap32(r_b + H1),
                  bswap32(r_c + H2), bswap32(r_d + H3)};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_digest <= '0;
`ifdef MD5_MATCH_EN
      r_match  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_blk   <= w_words;
          r_a     <= H0;
          r_b     <= H1;
          r_c     <= H2;
          r_d     <= H3;
          r_idx   <= '0;
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_a   <= w_a[UNROLL];
          r_b   <= w_b[UNROLL];
          r_c   <= w_c[UNROLL];
          r_d   <= w_d[UNROLL];
          r_idx <= r_idx + 6'(UNROLL);
          if (r_idx == LAST_IDX) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          r_digest <= w_dig;
`ifdef MD5_MATCH_EN
          r_match  <= (w_dig == bus.target);
`endif
          r_state  <= ST_OUT;
        end
        default: if (bus.out_ready) r_state <= ST_IDLE;
      endcase
    end
  end

  // gated by reset_n so the reset cycle itself never advertises ready
  assign bus.in_ready   = reset_n && (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_OUT);
  assign bus.out_digest = r_digest;
`ifdef MD5_MATCH_EN
  assign bus.out_match  = r_match;
`endif
endmodule

// File: tb/tb_md5_param_core.sv
// Scoreboard bench: three engines (UNROLL 1/4/16) share stimulus; a sine-derived MD5 model predicts digests.
module tb_md5_param_core;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [63:0]  in_data = '0;
  logic [5:0]   in_len = '0;
  logic         out_ready = 1'b1;
  logic [127:0] target = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_or = 1'b0;

  logic         rdy [3];
  logic         ov  [3];
  logic [127:0] od  [3];
  int           ur  [3] = '{1, 4, 16};
  logic [127:0] expq [3][$];
  logic [127:0] held [3];
  bit           seen [3] = '{0, 0, 0};
  int           acc  [3] = '{0, 0, 0};
  logic [127:0] e_dig;

  logic [31:0]  kt [64];
  int           sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  md5_param_core_if #(.MSG_BYTES(8)) b1 ();
  md5_param_core_if #(.MSG_BYTES(8)) b4 ();
  md5_param_core_if #(.MSG_BYTES(8)) b16 ();

  md5_param_core #(.MSG_BYTES(8), .UNROLL(1))  u1  (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  md5_param_core #(.MSG_BYTES(8), .UNROLL(4))  u4  (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  md5_param_core #(.MSG_BYTES(8), .UNROLL(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16.slave));

  assign b1.in_valid  = in_valid;  assign b4.in_valid  = in_valid;  assign b16.in_valid  = in_valid;
  assign b1.in_data   = in_data;   assign b4.in_data   = in_data;   assign b16.in_data   = in_data;
  assign b1.in_len    = in_len;    assign b4.in_len    = in_len;    assign b16.in_len    = in_len;
  assign b1.out_ready = out_ready; assign b4.out_ready = out_ready; assign b16.out_ready = out_ready;
  assign rdy[0] = b1.in_ready;   assign rdy[1] = b4.in_ready;   assign rdy[2] = b16.in_ready;
  assign ov[0]  = b1.out_valid;  assign ov[1]  = b4.out_valid;  assign ov[2]  = b16.out_valid;
  assign od[0]  = b1.out_digest; assign od[1]  = b4.out_digest; assign od[2]  = b16.out_digest;

`ifdef MD5_MATCH_EN
  logic om [3];
  logic mq [3][$];
  logic e_m;
  assign b1.target = target; assign b4.target = target; assign b16.target = target;
  assign om[0] = b1.out_match; assign om[1] = b4.out_match; assign om[2] = b16.out_match;
`else
  logic unused_target;
  assign unused_target = ^target;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  // Textbook MD5 over a 0..8 byte message (length clamped to 8)
  function automatic logic [127:0] md5_model(input logic [63:0] data, input int len);
    byte unsigned m [64];
    logic [31:0]  w [16];
    logic [31:0]  a, b, c, d, f, t;
    logic [63:0]  bits;
    logic [127:0] dg;
    int n, g, s;
    n = (len > 8) ? 8 : len;
    for (int i = 0; i < 64; i++) m[i] = 0;
    for (int i = 0; i < n; i++) m[i] = data[63-8*i -: 8];
    m[n] = 8'h80;
    bits = 64'(n * 8);
    for (int i = 0; i < 8; i++) m[56+i] = bits[8*i +: 8];
    for (int j = 0; j < 16; j++) w[j] = {m[4*j+3], m[4*j+2], m[4*j+1], m[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      s = sh[(i / 16) * 4 + i % 4];
      t = a + f + kt[i] + w[g];
      a = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    a += 32'h67452301; b += 32'hefcdab89; c += 32'h98badcfe; d += 32'h10325476;
    for (int i = 0; i < 4; i++) begin
      dg[127-8*i      -: 8] = a[8*i +: 8];
      dg[127-8*(i+4)  -: 8] = b[8*i +: 8];
      dg[127-8*(i+8)  -: 8] = c[8*i +: 8];
      dg[127-8*(i+12) -: 8] = d[8*i +: 8];
    end
    return dg;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2])) begin
      @(posedge clk); #1;
      n++;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL idle_timeout: engines not ready after %0d cycles, required ready", n);
        return;
      end
    end
  endtask

  task automatic send(input logic [63:0] d, input int len, input logic [127:0] known, input bit use_known);
    logic [127:0] e;
    e = md5_model(d, len);
    if (use_known) begin
      checks++;
      if (e !== known) begin
        errors++;
        $display("FAIL model_vector: model %h, required %h", e, known);
      end
      e = known;
    end
    wait_idle();
    in_valid = 1'b1;
    in_data  = d;
    in_len   = 6'(len);
    for (int l = 0; l < 3; l++) begin
      expq[l].push_back(e);
`ifdef MD5_MATCH_EN
      mq[l].push_back(e == target);
`endif
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_len   = 6'($urandom_range(0, 63));
  endtask

  // Monitor: pop on first out_valid cycle, then hold digest stable until handshake
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int l = 0; l < 3; l++) seen[l] = 1'b0;
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (in_valid && rdy[l]) acc[l] = cyc + 1;
        if (ov[l]) begin
          checks++;
          if (rdy[l]) begin
            errors++;
            $display("FAIL ready_in_out lane U=%0d: in_ready %0b, required 0", ur[l], rdy[l]);
          end
          if (!seen[l]) begin
            checks++;
            if (expq[l].size() == 0) begin
              errors++;
              $display("FAIL unexpected_out lane U=%0d: digest %h with nothing pending", ur[l], od[l]);
            end else begin
              e_dig = expq[l].pop_front();
              if (od[l] !== e_dig) begin
                errors++;
                $display("FAIL digest lane U=%0d: got %h, required %h", ur[l], od[l], e_dig);
              end
              checks++;
              if (cyc - acc[l] != 64 / ur[l] + 1) begin
                errors++;
                $display("FAIL latency lane U=%0d: %0d edges, required %0d", ur[l], cyc - acc[l], 64 / ur[l] + 1);
              end
`ifdef MD5_MATCH_EN
              e_m = mq[l].pop_front();
              checks++;
              if (om[l] !== e_m) begin
                errors++;
                $display("FAIL match lane U=%0d: got %0b, required %0b", ur[l], om[l], e_m);
              end
`endif
            end
            held[l] = od[l];
            seen[l] = 1'b1;
          end else begin
            checks++;
            if (od[l] !== held[l]) begin
              errors++;
              $display("FAIL digest_stable lane U=%0d: got %h, required %h", ur[l], od[l], held[l]);
            end
          end
          if (out_ready) seen[l] = 1'b0;
        end
      end
    end
  end

  task automatic check_all(input string name, input logic want_rdy, input logic want_ov, input bit chk_dig);
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (rdy[l] !== want_rdy || ov[l] !== want_ov || (chk_dig && od[l] !== 128'd0)) begin
        errors++;
        $display("FAIL %s lane U=%0d: in_ready %0b out_valid %0b digest %h, required %0b %0b%s",
                 name, ur[l], rdy[l], ov[l], od[l], want_rdy, want_ov, chk_dig ? " digest 0" : "");
      end
    end
  endtask

  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_PASS  = 128'h5f4dcc3b5aa765d61d8327deb882cf99;
  localparam logic [63:0]  M_ABC   = 64'h616263FFFFFFFFFF;
  localparam logic [63:0]  M_PASS  = 64'h70617373776f7264;

  initial begin
    real r;
    int n;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    // reset state
    @(negedge clk);
    check_all("reset_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("reset_vals", 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset", 1'b1, 1'b0, 1'b1);

    // known vectors, incl. masking of bytes past in_len and clamping of in_len
    send(M_ABC, 3, D_ABC, 1'b1);
    send(64'hFFFFFFFFFFFFFFFF, 0, D_EMPTY, 1'b1);
    send(M_PASS, 8, D_PASS, 1'b1);
    send(M_PASS, 20, D_PASS, 1'b1);

    // output backpressure with in_valid held high
    wait_idle();
    out_ready = 1'b0;
    send(M_PASS, 8, D_PASS, 1'b1);
    n = 0;
    while (!(ov[0] && ov[1] && ov[2]) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL bp_wait: out_valid %0b%0b%0b, required 111", ov[0], ov[1], ov[2]);
    end
    in_valid = 1'b1;
    in_data  = M_ABC;
    in_len   = 6'd3;
    repeat (20) begin
      @(negedge clk);
      check_all("bp_hold", 1'b0, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_all("bp_release", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("bp_ready_back", 1'b1, 1'b0, 1'b0);

`ifdef MD5_MATCH_EN
    wait_idle();
    target = D_PASS;
    send(M_PASS, 8, D_PASS, 1'b1);
    wait_idle();
    target = D_PASS ^ 128'd1;
    send(M_PASS, 8, D_PASS, 1'b1);
    wait_idle();
`endif

    // reset while the UNROLL=1 engine is at step 30
    send(M_ABC, 3, D_ABC, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    for (int l = 0; l < 3; l++) begin
      expq[l].delete();
`ifdef MD5_MATCH_EN
      mq[l].delete();
`endif
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_all("abort_reset", 1'b1, 1'b0, 1'b1);
    repeat (80) @(posedge clk);
    #1;
    send(M_ABC, 3, D_ABC, 1'b1);

    // randomized traffic with random output backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 12; i++) begin
      target = {$urandom, $urandom, $urandom, $urandom};
      send({$urandom, $urandom}, int'($urandom_range(0, 10)), 128'd0, 1'b0);
      wait_idle();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (expq[l].size() != 0) begin
        errors++;
        $display("FAIL drain lane U=%0d: %0d digests outstanding, required 0", ur[l], expq[l].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
